// File: rtl/seg_bcd_reader_pkg.sv
// Shared constants and types for the seven-segment to BCD frame reader.
// Glyph patterns are {A,B,C,D,E,F,G}, active-low.
package seg_bcd_reader_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_CODE  = 4'hF;
    localparam logic [3:0] ERR_CODE    = 4'hE;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment glyph decoder: decimal digits, blank, or error.
// Unrecognised patterns map to ERR_CODE with err_o set.
module seg_glyph_decode (
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       err_o
);
    import seg_bcd_reader_pkg::*;

    // Pattern lookup; anything outside the table is flagged as an error.
    always_comb begin
        code_o = ERR_CODE;
        err_o  = 1'b0;
        case (seg_i)
            GLYPH_0:     code_o = 4'd0;
            GLYPH_1:     code_o = 4'd1;
            GLYPH_2:     code_o = 4'd2;
            GLYPH_3:     code_o = 4'd3;
            GLYPH_4:     code_o = 4'd4;
            GLYPH_5:     code_o = 4'd5;
            GLYPH_6:     code_o = 4'd6;
            GLYPH_7:     code_o = 4'd7;
            GLYPH_8:     code_o = 4'd8;
            GLYPH_9:     code_o = 4'd9;
            GLYPH_BLANK: code_o = BLANK_CODE;
            default: begin
                code_o = ERR_CODE;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_bcd_reader.sv
// Recovers BCD frames from a multiplexed seven-segment display bus and
// presents them on a valid/ready interface with a sticky overrun flag.
module seg_bcd_reader #(
    parameter int unsigned N_DIG  = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg,
    input  logic [N_DIG-1:0]     dig_en,
    output logic [4*N_DIG-1:0]   bcd,
    output logic [N_DIG-1:0]     bcd_err,
    output logic                 bcd_valid,
    input  logic                 bcd_ready,
    output logic                 overrun
);
    import seg_bcd_reader_pkg::*;

    localparam logic [3:0]       STABLE_C = 4'(STABLE);
    localparam logic [N_DIG-1:0] ONE_DIG  = N_DIG'(1);
    localparam logic [N_DIG-1:0] ZERO_DIG = {N_DIG{1'b0}};

    logic [6:0]         prev_seg_q;
    logic [N_DIG-1:0]   prev_dig_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [4*N_DIG-1:0] shadow_q, shadow_d;
    logic [N_DIG-1:0]   shadow_err_q, shadow_err_d;
    logic [N_DIG-1:0]   seen_q, seen_d;
    state_e             state_q, state_d;
    logic [4*N_DIG-1:0] bcd_q, bcd_d;
    logic [N_DIG-1:0]   err_q, err_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic [3:0]         code_s;
    logic               err_s;
    logic               onehot_s;
    logic               same_s;
    logic               accept_s;
    logic [N_DIG-1:0]   seen_acc_s;
    logic               frame_done_s;

    seg_glyph_decode u_decode (
        .seg_i  (seg),
        .code_o (code_s),
        .err_o  (err_s)
    );

    assign onehot_s     = (dig_en != ZERO_DIG) && ((dig_en & (dig_en - ONE_DIG)) == ZERO_DIG);
    assign same_s       = onehot_s && (seg == prev_seg_q) && (dig_en == prev_dig_q);
    assign seen_acc_s   = accept_s ? dig_en : ZERO_DIG;
    assign frame_done_s = &seen_q;

    // Saturating dwell counter; the single accept fires on the step that reaches STABLE.
    always_comb begin
        cnt_d    = 4'd0;
        accept_s = 1'b0;
        if (same_s && (cnt_q == STABLE_C)) begin
            cnt_d = cnt_q;
        end else if (same_s) begin
            cnt_d    = cnt_q + 4'd1;
            accept_s = ((cnt_q + 4'd1) == STABLE_C);
        end else begin
            cnt_d    = 4'd0;
            accept_s = 1'b0;
        end
    end

    // Shadow bank write for the digit currently being accepted.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (accept_s && dig_en[i]) begin
                shadow_d[4*i +: 4] = code_s;
                shadow_err_d[i]    = err_s;
            end else begin
                shadow_d[4*i +: 4] = shadow_q[4*i +: 4];
                shadow_err_d[i]    = shadow_err_q[i];
            end
        end
    end

    // Frame FSM: an accept coinciding with frame completion starts the next frame's seen set.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        seen_d    = seen_q | seen_acc_s;
        case (state_q)
            COLLECT: begin
                if (frame_done_s) begin
                    bcd_d   = shadow_q;
                    err_d   = shadow_err_q;
                    seen_d  = seen_acc_s;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (bcd_ready && frame_done_s) begin
                    bcd_d   = shadow_q;
                    err_d   = shadow_err_q;
                    seen_d  = seen_acc_s;
                    valid_d = 1'b1;
                end else if (bcd_ready) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end else if (frame_done_s) begin
                    overrun_d = 1'b1;
                    seen_d    = seen_acc_s;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_seg_q   <= 7'd0;
            prev_dig_q   <= ZERO_DIG;
            cnt_q        <= 4'd0;
            shadow_q     <= {(4*N_DIG){1'b0}};
            shadow_err_q <= ZERO_DIG;
            seen_q       <= ZERO_DIG;
            state_q      <= COLLECT;
            bcd_q        <= {(4*N_DIG){1'b0}};
            err_q        <= ZERO_DIG;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            prev_seg_q   <= seg;
            prev_dig_q   <= dig_en;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            seen_q       <= seen_d;
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_err   = err_q;
    assign bcd_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/seg_bcd_reader.md
SEG_BCD_READER -- requirements
Module: seg_bcd_reader

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed display digits.
REQ-002 Parameter STABLE, default 3, consecutive identical cycles required before a digit is accepted; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg  input  7  segment bus {A,B,C,D,E,F,G}, A = MSB, active-low (0 = segment lit).
REQ-006 dig_en  input  N_DIG  digit select, active-high, bit 0 = least-significant digit; legal only when exactly one bit is set.
REQ-007 bcd  output  4*N_DIG  recovered frame, digit i in bits [4i+3:4i].
REQ-008 bcd_err  output  N_DIG  per-digit flag: the captured pattern was neither a decimal glyph nor blank.
REQ-009 bcd_valid  output  1  frame available; valid/ready handshake.
REQ-010 bcd_ready  input  1  consumer accepts the frame.
REQ-011 overrun  output  1  sticky flag: a completed frame was dropped because the previous frame was still pending.

Function
REQ-012 Glyph map, seg pattern to code: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; 1111111 (blank) = 4'hF, no error; any other pattern = 4'hE with the bcd_err bit set.
REQ-013 Stability counter: increments, saturating at STABLE, while seg and dig_en equal their previous-cycle values and dig_en is one-hot; otherwise it clears to 0.
REQ-014 Accept the digit in the cycle the counter reaches STABLE: write the decoded code and error bit into the shadow slot of the selected digit and set that slot's seen bit.
REQ-015 At most one accept per dwell; the next accept requires a change of seg or dig_en first.
REQ-016 A zero or multi-hot dig_en performs no accept and clears the counter.
REQ-017 State COLLECT: when all seen bits are set, copy the shadow slots to bcd/bcd_err, clear all seen bits, assert bcd_valid on the next cycle, and move to HOLD.
REQ-018 State HOLD: bcd, bcd_err and bcd_valid stay constant while bcd_ready=0; collection into the shadow slots continues.
REQ-019 In HOLD, bcd_valid & bcd_ready completes the transfer; go to COLLECT and deassert bcd_valid on the next cycle unless the shadow frame completes in that same cycle. In that case, load the new frame and stay valid, back-to-back, with no bubble.
REQ-020 In HOLD without ready, a shadow-frame completion sets overrun, clears the seen bits, and discards the shadow frame; the held output is unchanged.
REQ-021 overrun clears only on reset.
REQ-022 Latency: the last digit's stable period ends → bcd_valid is high two cycles later (accept cycle plus transfer cycle).
REQ-023 The decode is purely combinational on seg; the decoded code and error bit are registered only at accept.

Reset
REQ-024 While rst=1: state=COLLECT; bcd=0; bcd_err=0; bcd_valid=0; overrun=0; seen bits, shadow slots and counter are all 0.
REQ-025 Reset asserted mid-frame or in HOLD discards all partial and held data; the first frame after release needs a fresh accept of every digit.

Structure
REQ-026 Shared package holds the 7-bit glyph constants for codes 0-9 and blank, the BLANK_CODE (4'hF) and ERR_CODE (4'hE) constants, and the two-state enum {COLLECT, HOLD}.
REQ-027 One sub-module, seg_glyph_decode: combinational 7-bit to {4-bit code, err}, instantiated once on seg.
REQ-028 Sequential part (counter, shadow bank, FSM, handshake) lives in seg_bcd_reader.

Verification
REQ-029 N_DIG=4, STABLE=3; scan digits 0..3 with 0000110, 0100100, 0000000, 1001111, 4 cycles each, ready=1 → one bcd_valid pulse, bcd=16'h1853, bcd_err=0.
REQ-030 Digit 2 shows 1111110 → captured frame has nibble 2 = 4'hE and bcd_err=4'b0100.
REQ-031 Hold time 2 cycles per digit (below STABLE) → no accept, bcd_valid stays 0.
REQ-032 Two full frames while ready=0 → first frame held unchanged, overrun=1 after the second completion; raising ready → one transfer, then bcd_valid=0.
REQ-033 dig_en=4'b0011 for 5 cycles → no accept, counter stays 0.
REQ-034 rst pulsed after 3 of 4 digits are accepted → outputs 0; the next frame needs all 4 digits and matches the new stimulus only.
